mux_n_to_1_rr: RTL and testbench

Parametrised N-input, W-bit registered multiplexer with per-channel valid/ready handshakes and a one-entry output register. It generalises the 2:1 mux to N channels with two selection modes: explicit select, and round-robin over valid channels. It sits between several producer channels and one consumer, so a single downstream path can be shared without losing or duplicating words.

---
 rtl/mux_n_to_1_rr.sv | 109 ++++++++++
 tb/tb_mux_n_to_1_rr.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_rr.sv
// rtl/mux_n_to_1_rr.sv - N-to-1 registered mux with explicit-select and round-robin grant
// One-entry output register; a channel is accepted only when the register is empty or draining.
module mux_n_to_1_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] D,
  input  logic [N-1:0]   D_valid,
  output logic [N-1:0]   D_ready,
  input  logic [SW-1:0]  S,
  input  logic           mode,
  output logic [W-1:0]   Y,
  output logic           Y_valid,
  input  logic           Y_ready,
  output logic [SW-1:0]  Y_src
);

  logic [W-1:0]   y_q, y_d;
  logic           y_valid_q, y_valid_d;
  logic [SW-1:0]  y_src_q, y_src_d;
  logic [SW-1:0]  ptr_q, ptr_d;

  logic           load;
  logic           grant_valid;
  logic [SW-1:0]  grant_idx;
  logic [W-1:0]   grant_data;
  logic [2*N-1:0] valid_dup;
  logic [N-1:0]   valid_rot;
  logic [SW:0]    rr_sum;

  assign load      = !y_valid_q || Y_ready;
  assign valid_dup = {D_valid, D_valid};

  // Round-robin: rotate valids so bit 0 is channel ptr, pick the lowest set bit,
  // then map the offset back to an absolute channel index modulo N.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    valid_rot   = valid_dup[ptr_q +: N];
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (S == SW'(i) && D_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (valid_rot[k]) begin
          grant_valid = 1'b1;
          rr_sum      = {1'b0, ptr_q} + (SW+1)'(k);
        end
      end
      if (rr_sum >= (SW+1)'(N)) rr_sum = rr_sum - (SW+1)'(N);
      grant_idx = rr_sum[SW-1:0];
    end
  end

  always_comb begin
    grant_data = '0;
    D_ready    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = D[i*W +: W];
        D_ready[i] = !rst && load && grant_valid;
      end
    end
  end

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_src_d   = y_src_q;
    ptr_d     = ptr_q;
    if (load) begin
      if (grant_valid) begin
        y_d       = grant_data;
        y_src_d   = grant_idx;
        y_valid_d = 1'b1;
        ptr_d     = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_src_q   <= '0;
      ptr_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_src_q   <= y_src_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Y       = y_q;
  assign Y_valid = y_valid_q;
  assign Y_src   = y_src_q;

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// tb/tb_mux_n_to_1_rr.sv - scoreboard bench for mux_n_to_1_rr with directed and random stimulus
module tb_mux_n_to_1_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] D;
  logic [N-1:0]   D_valid;
  logic [N-1:0]   D_ready;
  logic [SW-1:0]  S;
  logic           mode;
  logic [W-1:0]   Y;
  logic           Y_valid;
  logic           Y_ready;
  logic [SW-1:0]  Y_src;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  int mptr     = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  mux_n_to_1_rr #(.N(N), .W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .D(D), .D_valid(D_valid), .D_ready(D_ready),
    .S(S), .mode(mode), .Y(Y), .Y_valid(Y_valid), .Y_ready(Y_ready), .Y_src(Y_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // The queue mirrors the output register: empty means Y_valid low, one entry is the word on Y.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        chk("mon_y_valid_empty", 32'(Y_valid), 32'd0);
      end else begin
        chk("mon_y_valid_full", 32'(Y_valid), 32'd1);
        chk("mon_y", 32'(Y), 32'(sb_q[0][7:0]));
        chk("mon_y_src", 32'(Y_src), 32'(sb_q[0][9:8]));
        if (Y_ready) void'(sb_q.pop_front());
      end
    end
  end

  // Reference: decide the grant from the rules, check D_ready, enqueue the accepted word.
  task automatic model_eval();
    int g;
    logic [N-1:0] exp_ready;
    g = -1;
    exp_ready = '0;
    if (rst) begin
      chk("ready_in_reset", 32'(D_ready), 32'd0);
      sb_q.delete();
      mptr = 0;
    end else begin
      if (sb_q.size() == 0) begin
        if (mode == 1'b0) begin
          if (int'(S) < N && D_valid[S]) g = int'(S);
        end else begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && D_valid[(mptr + k) % N]) g = (mptr + k) % N;
          end
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("d_ready", 32'(D_ready), 32'(exp_ready));
      if (g >= 0) begin
        sb_q.push_back({2'(g), D[g*W +: W]});
        mptr = (g + 1) % N;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
    model_eval();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst = 1'b1; D = 32'h44332211; D_valid = 4'hF; S = '0; mode = 1'b1; Y_ready = 1'b1;
    @(posedge clk); #1;
    cycle();
    cycle();
    chk("reset_y", 32'(Y), 32'h00);
    chk("reset_y_valid", 32'(Y_valid), 32'd0);
    chk("reset_y_src", 32'(Y_src), 32'd0);
    mon_en = 1'b1;

    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_wrap_src", 32'(Y_src), 32'(i % 4));
      chk("rr_wrap_y", 32'(Y), 32'(rr_data[i % 4]));
    end

    mode = 1'b0; S = 2'd2;
    cycle();
    chk("sel_y", 32'(Y), 32'h33);
    chk("sel_src", 32'(Y_src), 32'd2);
    S = 2'd3; D_valid = 4'b0111;
    cycle();
    chk("sel_invalid_drop", 32'(Y_valid), 32'd0);

    S = 2'd0; D_valid = 4'hF;
    cycle();
    mode = 1'b1; D_valid = 4'b1001;
    cycle();
    chk("rr_skip_a", 32'(Y_src), 32'd3);
    cycle();
    chk("rr_skip_b", 32'(Y_src), 32'd0);
    cycle();
    chk("rr_skip_c", 32'(Y_src), 32'd3);

    mode = 1'b0; S = 2'd1; D_valid = 4'hF;
    cycle();
    chk("bp_load_y", 32'(Y), 32'h22);
    Y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_stall_y", 32'(Y), 32'h22);
      chk("bp_stall_src", 32'(Y_src), 32'd1);
      chk("bp_stall_valid", 32'(Y_valid), 32'd1);
    end
    Y_ready = 1'b1; S = 2'd2;
    cycle();
    chk("bp_release_y", 32'(Y), 32'h33);
    chk("bp_release_valid", 32'(Y_valid), 32'd1);

    Y_ready = 1'b0; rst = 1'b1;
    cycle();
    chk("midrst_valid", 32'(Y_valid), 32'd0);
    chk("midrst_y", 32'(Y), 32'h00);
    rst = 1'b0; mode = 1'b1; Y_ready = 1'b1; D_valid = 4'hF;
    cycle();
    chk("midrst_rr_first", 32'(Y_src), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      D       = $urandom;
      D_valid = 4'($urandom);
      S       = 2'($urandom);
      mode    = 1'($urandom);
      Y_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 150) == 0);
      cycle();
    end

    rst = 1'b0; D_valid = '0; Y_ready = 1'b1;
    cycle();
    cycle();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
